matmul_loader: RTL and testbench

- Upstream feeder for the matrix multiplier block.
- Accepts a byte stream from the host over a valid/ready handshake and parses a 2-byte dimension header.
- Checks dimension legality, then replays operand A followed by operand B, row-major, one element per program_val cycle.
- Raises start, holds it until the multiplier reports ready, then pulses done. One job per frame.

---
 rtl/matmul_loader_pkg.sv | 23 ++
 rtl/matmul_loader_if.sv | 32 +++
 rtl/matmul_loader_hdr_check.sv | 34 +++
 rtl/matmul_loader.sv | 162 ++++++++++++++++
 tb/tb_matmul_loader.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/matmul_loader_pkg.sv
// Shared types and constants for the matrix-multiplier loader and its header checker.
package matmul_pkg;

    localparam int DEF_DIM_W  = 3;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        CHECK,
        LOAD_A,
        LOAD_B,
        GAP,
        START,
        ERR
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ZERO     = 2'b01;
    localparam logic [1:0] ERR_MISMATCH = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/matmul_loader_if.sv
// Host byte stream plus the loader-to-multiplier operand/control bus.
interface matmul_loader_if
    import matmul_pkg::*;
#(
    parameter int DIM_W  = DEF_DIM_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DIM_W-1:0]  m1x;
    logic [DIM_W-1:0]  m1y;
    logic [DIM_W-1:0]  m2x;
    logic [DIM_W-1:0]  m2y;
    logic              program_dim;
    logic              program_val;
    logic [DATA_W-1:0] data_out;
    logic              start;
    logic              mm_ready;

    modport master (
        output s_data, s_valid, mm_ready,
        input  s_ready, m1x, m1y, m2x, m2y, program_dim, program_val, data_out, start
    );

    modport slave (
        input  s_data, s_valid, mm_ready,
        output s_ready, m1x, m1y, m2x, m2y, program_dim, program_val, data_out, start
    );

endinterface

// File: rtl/matmul_loader_hdr_check.sv
// Combinational dimension legality check and operand element counts for one job.
module matmul_hdr_check
    import matmul_pkg::*;
#(
    parameter int DIM_W = DEF_DIM_W,
    parameter int CNT_W = 2 * DIM_W + 1
) (
    input  logic [DIM_W-1:0] i_m1x,
    input  logic [DIM_W-1:0] i_m1y,
    input  logic [DIM_W-1:0] i_m2x,
    input  logic [DIM_W-1:0] i_m2y,
    output logic             o_legal,
    output logic [1:0]       o_err_code,
    output logic [CNT_W-1:0] o_na,
    output logic [CNT_W-1:0] o_nb
);

    assign o_na = CNT_W'(i_m1x) * CNT_W'(i_m1y);
    assign o_nb = CNT_W'(i_m2x) * CNT_W'(i_m2y);

    // A zero dimension takes priority over an inner-dimension mismatch
    always_comb begin
        o_legal    = 1'b0;
        o_err_code = ERR_NONE;
        if ((i_m1x == '0) || (i_m1y == '0) || (i_m2x == '0) || (i_m2y == '0)) begin
            o_err_code = ERR_ZERO;
        end else if (i_m1y != i_m2x) begin
            o_err_code = ERR_MISMATCH;
        end else begin
            o_legal = 1'b1;
        end
    end

endmodule

// File: rtl/matmul_loader.sv
// Parses a dimension header from the host stream, replays operands A then B, and
// runs the start/mm_ready handshake with a bounded wait.
module matmul_loader
    import matmul_pkg::*;
#(
    parameter int DIM_W       = DEF_DIM_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic            clk,
    input  logic            rst_n,
    matmul_loader_if.slave  bus,
    input  logic            i_err_clr,
    output logic            o_done,
    output logic            o_err,
    output logic [1:0]      o_err_code
);

    localparam int CNT_W = 2 * DIM_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    state_t            r_state;
    logic [DIM_W-1:0]  r_m1x, r_m1y, r_m2x, r_m2y;
    logic [CNT_W-1:0]  r_na, r_nb, r_elem_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_program_dim, r_program_val, r_start, r_done, r_err;
    logic [DATA_W-1:0] r_data_out;
    logic [1:0]        r_err_code;

    logic              w_s_ready, w_xfer, w_legal;
    logic [1:0]        w_code;
    logic [CNT_W-1:0]  w_na, w_nb;

    matmul_hdr_check #(.DIM_W(DIM_W), .CNT_W(CNT_W)) u_hdr_check (
        .i_m1x      (r_m1x),
        .i_m1y      (r_m1y),
        .i_m2x      (r_m2x),
        .i_m2y      (r_m2y),
        .o_legal    (w_legal),
        .o_err_code (w_code),
        .o_na       (w_na),
        .o_nb       (w_nb)
    );

    // Byte acceptance depends only on the current state
    always_comb begin
        w_s_ready = 1'b0;
        case (r_state)
            HDR0, HDR1, LOAD_A, LOAD_B: w_s_ready = 1'b1;
            default:                    w_s_ready = 1'b0;
        endcase
    end

    assign w_xfer = bus.s_valid && w_s_ready;

    // Main job sequencer with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= HDR0;
            r_m1x         <= '0;
            r_m1y         <= '0;
            r_m2x         <= '0;
            r_m2y         <= '0;
            r_na          <= '0;
            r_nb          <= '0;
            r_elem_cnt    <= '0;
            r_to_cnt      <= '0;
            r_program_dim <= 1'b0;
            r_program_val <= 1'b0;
            r_data_out    <= '0;
            r_start       <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_err_code    <= ERR_NONE;
        end else begin
            r_program_dim <= 1'b0;
            r_program_val <= 1'b0;
            r_done        <= 1'b0;
            case (r_state)
                HDR0: if (w_xfer) begin
                    r_m1x   <= bus.s_data[4 +: DIM_W];
                    r_m1y   <= bus.s_data[0 +: DIM_W];
                    r_state <= HDR1;
                end
                HDR1: if (w_xfer) begin
                    r_m2x   <= bus.s_data[4 +: DIM_W];
                    r_m2y   <= bus.s_data[0 +: DIM_W];
                    r_state <= CHECK;
                end
                CHECK: if (w_legal) begin
                    r_na          <= w_na;
                    r_nb          <= w_nb;
                    r_elem_cnt    <= '0;
                    r_program_dim <= 1'b1;
                    r_state       <= LOAD_A;
                end else begin
                    r_err      <= 1'b1;
                    r_err_code <= w_code;
                    r_state    <= ERR;
                end
                LOAD_A: if (w_xfer) begin
                    r_data_out    <= bus.s_data;
                    r_program_val <= 1'b1;
                    if (r_elem_cnt == r_na - CNT_W'(1)) begin
                        r_elem_cnt <= '0;
                        r_state    <= LOAD_B;
                    end else begin
                        r_elem_cnt <= r_elem_cnt + CNT_W'(1);
                    end
                end
                LOAD_B: if (w_xfer) begin
                    r_data_out    <= bus.s_data;
                    r_program_val <= 1'b1;
                    if (r_elem_cnt == r_nb - CNT_W'(1)) begin
                        r_elem_cnt <= '0;
                        r_state    <= GAP;
                    end else begin
                        r_elem_cnt <= r_elem_cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    r_start  <= 1'b1;
                    r_to_cnt <= '0;
                    r_state  <= START;
                end
                // start has been high for r_to_cnt+1 cycles when evaluated here
                START: if (bus.mm_ready) begin
                    r_start <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= HDR0;
                end else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    r_start    <= 1'b0;
                    r_err      <= 1'b1;
                    r_err_code <= ERR_TIMEOUT;
                    r_state    <= ERR;
                end else begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
                ERR: if (i_err_clr) begin
                    r_err      <= 1'b0;
                    r_err_code <= ERR_NONE;
                    r_state    <= HDR0;
                end
                default: r_state <= HDR0;
            endcase
        end
    end

    assign bus.s_ready     = w_s_ready;
    assign bus.m1x         = r_m1x;
    assign bus.m1y         = r_m1y;
    assign bus.m2x         = r_m2x;
    assign bus.m2y         = r_m2y;
    assign bus.program_dim = r_program_dim;
    assign bus.program_val = r_program_val;
    assign bus.data_out    = r_data_out;
    assign bus.start       = r_start;
    assign o_done          = r_done;
    assign o_err           = r_err;
    assign o_err_code      = r_err_code;

endmodule

// File: tb/tb_matmul_loader.sv
// Randomised self-checking bench for matmul_loader against a frame-level reference model.
module tb_matmul_loader;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       err_clr = 1'b0;
    logic       done, err;
    logic [1:0] err_code;

    matmul_loader_if bus ();

    matmul_loader #(.TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .i_err_clr  (err_clr),
        .o_done     (done),
        .o_err      (err),
        .o_err_code (err_code)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [7:0] got_q[$];
    int pdim_cnt = 0, pv_cnt = 0, overlap_cnt = 0, pv_bad = 0;

    // Passive monitor of the multiplier-facing outputs
    always @(negedge clk) begin
        if (bus.program_val) begin
            got_q.push_back(bus.data_out);
            pv_cnt++;
        end
        if (bus.program_dim) pdim_cnt++;
        if (bus.program_val && bus.start) overlap_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer one byte with random idle gaps; verify program_val follows each transfer by one cycle
    task automatic send_byte(input logic [7:0] b, input bit payload, input int gap_pct);
        bit xfer = 1'b0;
        int tries = 0;
        while (!xfer && tries < 400) begin
            tries++;
            bus.s_valid  = ($urandom_range(99) >= gap_pct);
            bus.s_data   = bus.s_valid ? b : 8'($urandom);
            bus.mm_ready = 1'($urandom);
            xfer = bus.s_valid && bus.s_ready;
            step();
            if (bus.program_val !== (xfer && payload)) pv_bad++;
            else if (bus.program_val && (bus.data_out !== b)) pv_bad++;
        end
        if (!xfer) pv_bad++;
        bus.s_valid  = 1'b0;
        bus.mm_ready = 1'b0;
    endtask

    function automatic logic [1:0] model_code(input logic [7:0] h0, input logic [7:0] h1);
        int a = h0[6:4];
        int b = h0[2:0];
        int c = h1[6:4];
        int d = h1[2:0];
        if (a == 0 || b == 0 || c == 0 || d == 0) return 2'b01;
        if (b != c) return 2'b10;
        return 2'b00;
    endfunction

    task automatic clear_err();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_err", err, 1'b0);
        chk("clr_code", err_code, 2'b00);
        chk("clr_sready", bus.s_ready, 1'b1);
    endtask

    task automatic run_frame(input logic [7:0] h0, input logic [7:0] h1, input int gap_pct,
                             input int rdy_delay, input bit timeout, input bit seq);
        logic [1:0] ec;
        int na, nb, cnt, mism;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        ec = model_code(h0, h1);
        na = h0[6:4] * h0[2:0];
        nb = h1[6:4] * h1[2:0];
        got_q.delete();
        pdim_cnt = 0; pv_cnt = 0; overlap_cnt = 0; pv_bad = 0;
        send_byte(h0, 1'b0, gap_pct);
        send_byte(h1, 1'b0, gap_pct);
        chk("check_sready", bus.s_ready, 1'b0);
        step();
        if (ec != 2'b00) begin
            chk("err_flag", err, 1'b1);
            chk("err_code", err_code, ec);
            chk("err_sready", bus.s_ready, 1'b0);
            repeat (3) step();
            chk("err_sticky", {err, err_code}, {1'b1, ec});
            clear_err();
            chk("no_pdim", pdim_cnt, 0);
            chk("no_pval", pv_cnt, 0);
        end else begin
            chk("pdim", bus.program_dim, 1'b1);
            chk("dims", {bus.m1x, bus.m1y, bus.m2x, bus.m2y}, {h0[6:4], h0[2:0], h1[6:4], h1[2:0]});
            for (int i = 0; i < na + nb; i++) begin
                b = seq ? 8'(i + 1) : 8'($urandom);
                exp_q.push_back(b);
                send_byte(b, 1'b1, gap_pct);
            end
            chk("gap_start", bus.start, 1'b0);
            step();
            chk("start_on", bus.start, 1'b1);
            if (timeout) begin
                cnt = 1;
                while (bus.start && cnt < 4 * TO) begin
                    step();
                    if (bus.start) cnt++;
                end
                chk("start_len", cnt, TO);
                chk("to_err", {err, err_code}, {1'b1, 2'b11});
                chk("to_done", done, 1'b0);
                clear_err();
            end else begin
                repeat (rdy_delay) step();
                chk("start_hold", bus.start, 1'b1);
                bus.mm_ready = 1'b1;
                step();
                bus.mm_ready = 1'b0;
                chk("start_off", bus.start, 1'b0);
                chk("done", done, 1'b1);
                step();
                chk("done_pulse", done, 1'b0);
                chk("idle_sready", bus.s_ready, 1'b1);
            end
            chk("pv_count", pv_cnt, na + nb);
            mism = 0;
            for (int i = 0; i < exp_q.size(); i++)
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) mism++;
            chk("pv_data", mism, 0);
            chk("overlap", overlap_cnt, 0);
            chk("pdim_once", pdim_cnt, 1);
        end
        chk("pv_timing", pv_bad, 0);
    endtask

    initial begin
        logic [2:0] a, bb, c, d;
        bus.s_valid = 1'b0;
        bus.s_data = 8'h00;
        bus.mm_ready = 1'b0;
        #17;
        chk("rst_outs", {bus.m1x, bus.m1y, bus.m2x, bus.m2y, bus.program_dim, bus.program_val,
                         bus.data_out, bus.start, done, err, err_code}, 32'h0);
        chk("rst_sready", bus.s_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(8'h23, 8'h32, 0, 5, 1'b0, 1'b1);
        run_frame(8'h23, 8'h22, 0, 0, 1'b0, 1'b0);
        run_frame(8'h03, 8'h32, 0, 0, 1'b0, 1'b0);
        run_frame(8'h99, 8'h11, 50, 2, 1'b0, 1'b0);
        run_frame(8'h12, 8'hA3, 20, 0, 1'b1, 1'b0);

        // Abort a frame partway through operand A with an asynchronous reset
        send_byte(8'h23, 1'b0, 0);
        send_byte(8'h32, 1'b0, 0);
        step();
        send_byte(8'h11, 1'b1, 0);
        send_byte(8'h22, 1'b1, 0);
        send_byte(8'h33, 1'b1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outs", {bus.m1x, bus.m1y, bus.m2x, bus.m2y, bus.program_dim, bus.program_val,
                               bus.data_out, bus.start, done, err, err_code}, 32'h0);
        chk("async_rst_sready", bus.s_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(8'h23, 8'h32, 0, 3, 1'b0, 1'b1);

        for (int k = 0; k < 8; k++) begin
            a  = 3'($urandom_range(1, 7));
            bb = 3'($urandom_range(0, 7));
            c  = ($urandom_range(3) == 0) ? 3'($urandom_range(0, 7)) : bb;
            d  = 3'($urandom_range(1, 7));
            run_frame({1'($urandom), a, 1'($urandom), bb}, {1'($urandom), c, 1'($urandom), d},
                      $urandom_range(0, 60), $urandom_range(0, 6), ($urandom_range(3) == 0), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
